if_fetch: RTL



---
 rtl/if_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage for the tinyMIPS pipeline.
// Owns the fetch PC, issues single-outstanding requests to instruction
// memory over a req/ack handshake, and presents {pc, inst} pairs through a
// one-slot output register backed by a one-entry skid buffer. Branch
// redirects from decode take priority over everything except reset.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst,
   output logic              if_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FLUSH = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] PC_RESET = RESET_PC[ADDR_W-1:0];

   state_t            state;

   // Skid buffer: catches the one instruction accepted while the slot is
   // full and not being drained.
   logic              skid_valid;
   logic [ADDR_W-1:0] skid_pc;
   logic [31:0]       skid_inst;

   // Redirect target remembered while the flushed request is still in flight.
   logic [ADDR_W-1:0] redirect_pc;

   // Handshake events seen at the coming edge.
   logic              consume;
   logic              accept;
   logic              slot_free;
   logic [ADDR_W-1:0] branch_pc;

   // Event decode shared by every branch of the state register.
   always_comb begin
      consume   = if_valid && !stall;
      accept    = imem_req && imem_ack;
      slot_free = !if_valid || consume;
      branch_pc = {branch_target[ADDR_W-1:2], 2'b00};
   end

   // Fetch FSM with its registered outputs, slot, skid and redirect latch.
   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours; reset is
   // synchronous, so it is just the highest-priority branch inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         imem_req    <= 1'b0;
         imem_addr   <= PC_RESET;
         if_pc       <= '0;
         if_inst     <= '0;
         if_valid    <= 1'b0;
         skid_valid  <= 1'b0;
         skid_pc     <= '0;
         skid_inst   <= '0;
         redirect_pc <= PC_RESET;
      end else if (branch_flag) begin
         // Redirect: kill everything presented or buffered.
         if_valid   <= 1'b0;
         skid_valid <= 1'b0;
         if (imem_req && !imem_ack) begin
            // A request is in flight; it must complete before the new one.
            redirect_pc <= branch_pc;
            state       <= FLUSH;
         end else begin
            // Nothing in flight (or it completes now and is dropped).
            imem_addr <= branch_pc;
            imem_req  <= 1'b1;
            state     <= WAIT;
         end
      end else begin
         case (state)
            IDLE: begin
               imem_req <= 1'b1;
               state    <= WAIT;
            end

            WAIT: begin
               if (accept) begin
                  imem_addr <= imem_addr + PC_STEP;
                  if (slot_free) begin
                     if_pc    <= imem_addr;
                     if_inst  <= imem_rdata;
                     if_valid <= 1'b1;
                  end else begin
                     skid_pc    <= imem_addr;
                     skid_inst  <= imem_rdata;
                     skid_valid <= 1'b1;
                     imem_req   <= 1'b0;
                     state      <= HOLD;
                  end
               end else if (consume) begin
                  if_valid <= 1'b0;
               end
            end

            HOLD: begin
               if (consume) begin
                  if_pc      <= skid_pc;
                  if_inst    <= skid_inst;
                  if_valid   <= 1'b1;
                  skid_valid <= 1'b0;
                  imem_req   <= 1'b1;
                  state      <= WAIT;
               end
            end

            FLUSH: begin
               if (consume) begin
                  if_valid <= 1'b0;
               end
               if (imem_ack) begin
                  // Stale instruction returned: drop it and chase the redirect.
                  imem_addr <= redirect_pc;
                  state     <= WAIT;
               end
            end

            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
